draw_region_scan: RTL and testbench

- Parametrised successor to the full-screen draw sequencer.
- On a start pulse it walks an arbitrary rectangle (corners in any order, clipped to the screen) and emits one pixel coordinate per accepted handshake.
- Three scan modes are supported, with valid/ready backpressure, abort, and a pixel counter.
- Sits between the game/scene controller and the framebuffer write port.

---
 rtl/draw_region_scan_if.sv | 31 +++
 rtl/draw_region_scan.sv | 178 +++++++++++++++++
 tb/tb_draw_region_scan.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/draw_region_scan_if.sv
// Handshake/bus bundle between the scene controller and the region scanner.
interface draw_region_scan_if #(
  parameter int CORDW = 11
);
  logic                    start;
  logic                    abort;
  logic [1:0]              mode;
  logic signed [CORDW-1:0] x0;
  logic signed [CORDW-1:0] y0;
  logic signed [CORDW-1:0] x1;
  logic signed [CORDW-1:0] y1;
  logic                    draw_ready;
  logic signed [CORDW-1:0] draw_X;
  logic signed [CORDW-1:0] draw_Y;
  logic                    draw_valid;
  logic                    busy;
  logic                    done;
  logic [2*CORDW-1:0]      pix_count;

  // Controller side: issues requests, consumes coordinates.
  modport master (
    output start, abort, mode, x0, y0, x1, y1, draw_ready,
    input  draw_X, draw_Y, draw_valid, busy, done, pix_count
  );

  // Scanner side.
  modport slave (
    input  start, abort, mode, x0, y0, x1, y1, draw_ready,
    output draw_X, draw_Y, draw_valid, busy, done, pix_count
  );
endinterface

// File: rtl/draw_region_scan.sv
// Rectangle scanner: walks a clipped, normalised region and emits one
// coordinate per valid/ready handshake in row-fill, outline or column-fill order.
module draw_region_scan #(
  parameter int CORDW = 11,
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input logic               clk,
  input logic               rst,
  draw_region_scan_if.slave bus
);

  typedef enum logic [1:0] {IDLE, INIT, DRAW, DONE} state_t;
  typedef enum logic [1:0] {M_FILL_ROW, M_OUTLINE, M_FILL_COL} scan_t;

  localparam logic signed [CORDW-1:0] ZERO  = '0;
  localparam logic signed [CORDW-1:0] ONE   = CORDW'(1);
  localparam logic signed [CORDW-1:0] X_MAX = CORDW'(H_RES - 1);
  localparam logic signed [CORDW-1:0] Y_MAX = CORDW'(V_RES - 1);

  state_t                  state;
  scan_t                   scan;
  logic signed [CORDW-1:0] cx0, cy0, cx1, cy1;
  logic signed [CORDW-1:0] xa, xb, ya, yb;
  logic signed [CORDW-1:0] draw_x, draw_y;
  logic                    draw_valid, busy, done;
  logic [2*CORDW-1:0]      pix_count;

  logic signed [CORDW-1:0] lo_x, hi_x, lo_y, hi_y;
  logic signed [CORDW-1:0] nxa, nxb, nya, nyb;
  logic                    empty;
  logic signed [CORDW-1:0] next_x, next_y;
  logic                    last;

  assign bus.draw_X     = draw_x;
  assign bus.draw_Y     = draw_y;
  assign bus.draw_valid = draw_valid;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.pix_count  = pix_count;

  // Normalise latched corners, then clip them to the visible screen.
  always_comb begin
    lo_x  = (cx0 < cx1) ? cx0 : cx1;
    hi_x  = (cx0 < cx1) ? cx1 : cx0;
    lo_y  = (cy0 < cy1) ? cy0 : cy1;
    hi_y  = (cy0 < cy1) ? cy1 : cy0;
    nxa   = (lo_x < ZERO)  ? ZERO  : lo_x;
    nxb   = (hi_x > X_MAX) ? X_MAX : hi_x;
    nya   = (lo_y < ZERO)  ? ZERO  : lo_y;
    nyb   = (hi_y > Y_MAX) ? Y_MAX : hi_y;
    empty = (nxa > nxb) || (nya > nyb);
  end

  // Next coordinate after a handshake, per scan order.
  // Outline interior rows jump straight from xa to xb so no pixel repeats.
  always_comb begin
    next_x = draw_x;
    next_y = draw_y;
    last   = (draw_x == xb) && (draw_y == yb);
    case (scan)
      M_FILL_COL: begin
        if (draw_y == yb) begin
          next_y = ya;
          next_x = draw_x + ONE;
        end else begin
          next_y = draw_y + ONE;
        end
      end
      M_OUTLINE: begin
        if (draw_x == xb) begin
          next_x = xa;
          next_y = draw_y + ONE;
        end else if ((draw_y == ya) || (draw_y == yb)) begin
          next_x = draw_x + ONE;
        end else begin
          next_x = xb;
        end
      end
      default: begin
        if (draw_x == xb) begin
          next_x = xa;
          next_y = draw_y + ONE;
        end else begin
          next_x = draw_x + ONE;
        end
      end
    endcase
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      scan       <= M_FILL_ROW;
      cx0        <= '0;
      cy0        <= '0;
      cx1        <= '0;
      cy1        <= '0;
      xa         <= '0;
      xb         <= '0;
      ya         <= '0;
      yb         <= '0;
      draw_x     <= '0;
      draw_y     <= '0;
      draw_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pix_count  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            cx0       <= bus.x0;
            cy0       <= bus.y0;
            cx1       <= bus.x1;
            cy1       <= bus.y1;
            case (bus.mode)
              2'd1:    scan <= M_OUTLINE;
              2'd2:    scan <= M_FILL_COL;
              default: scan <= M_FILL_ROW;
            endcase
            pix_count <= '0;
            busy      <= 1'b1;
            state     <= INIT;
          end
        end
        INIT: begin
          if (bus.abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            xa <= nxa;
            xb <= nxb;
            ya <= nya;
            yb <= nyb;
            if (empty) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              draw_x     <= nxa;
              draw_y     <= nya;
              draw_valid <= 1'b1;
              state      <= DRAW;
            end
          end
        end
        DRAW: begin
          if (bus.abort) begin
            draw_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (bus.draw_ready) begin
            pix_count <= pix_count + (2*CORDW)'(1);
            if (last) begin
              draw_valid <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              state      <= DONE;
            end else begin
              draw_x <= next_x;
              draw_y <= next_y;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_draw_region_scan.sv
// Directed bench for draw_region_scan: table of region scans plus
// hand-written backpressure, abort, reset and ignored-start sequences.
module tb_draw_region_scan;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  draw_region_scan_if #(.CORDW(11)) bus ();

  draw_region_scan #(.CORDW(11), .H_RES(640), .V_RES(480)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Expected pixel k = (bx + ex[4k+:4], by + ey[4k+:4]).
  typedef struct packed {
    logic [1:0]         mode;
    logic signed [10:0] x0, y0, x1, y1;
    logic [7:0]         n;
    logic [10:0]        bx, by;
    logic [39:0]        ex, ey;
  } vec_t;

  int total  = 0;
  int passed = 0;
  vec_t vecs[9];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic vec_t mk(input int mode, input int x0, input int y0,
                              input int x1, input int y1, input int n,
                              input int bx, input int by,
                              input logic [39:0] ex, input logic [39:0] ey);
    vec_t v;
    v.mode = 2'(mode);
    v.x0 = 11'(x0); v.y0 = 11'(y0); v.x1 = 11'(x1); v.y1 = 11'(y1);
    v.n = 8'(n); v.bx = 11'(bx); v.by = 11'(by);
    v.ex = ex; v.ey = ey;
    return v;
  endfunction

  task automatic set_region(input int mode, input int x0, input int y0,
                            input int x1, input int y1);
    bus.mode = 2'(mode);
    bus.x0 = 11'(x0); bus.y0 = 11'(y0); bus.x1 = 11'(x1); bus.y1 = 11'(y1);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    set_region(int'(v.mode), int'(v.x0), int'(v.y0), int'(v.x1), int'(v.y1));
    bus.draw_ready = 1'b1;
    pulse_start();
    chk($sformatf("v%0d init busy", idx), longint'(bus.busy), 1);
    chk($sformatf("v%0d init valid", idx), longint'(bus.draw_valid), 0);
    for (int k = 0; k < int'(v.n); k++) begin
      @(posedge clk); #1;
      chk($sformatf("v%0d p%0d valid", idx, k), longint'(bus.draw_valid), 1);
      chk($sformatf("v%0d p%0d X", idx, k), longint'(bus.draw_X),
          longint'(int'(v.bx) + int'(v.ex[4*k +: 4])));
      chk($sformatf("v%0d p%0d Y", idx, k), longint'(bus.draw_Y),
          longint'(int'(v.by) + int'(v.ey[4*k +: 4])));
      chk($sformatf("v%0d p%0d cnt", idx, k), longint'(bus.pix_count), longint'(k));
    end
    @(posedge clk); #1;
    chk($sformatf("v%0d done", idx), longint'(bus.done), 1);
    chk($sformatf("v%0d done valid", idx), longint'(bus.draw_valid), 0);
    chk($sformatf("v%0d done busy", idx), longint'(bus.busy), 0);
    chk($sformatf("v%0d total", idx), longint'(bus.pix_count), longint'(v.n));
    @(posedge clk); #1;
    chk($sformatf("v%0d done pulse", idx), longint'(bus.done), 0);
    chk($sformatf("v%0d idle busy", idx), longint'(bus.busy), 0);
  endtask

  initial begin
    vecs[0] = mk(0,  2,  3,   4,   4, 6,   0,   0, 40'h432432,   40'h444333);
    vecs[1] = mk(1,  3,  2,   0,   0, 10,  0,   0, 40'h3210303210, 40'h2222110000);
    vecs[2] = mk(2,  1,  1,   2,   2, 4,   0,   0, 40'h2211,     40'h2121);
    vecs[3] = mk(0, -2, -1,   1,   0, 2,   0,   0, 40'h10,       40'h00);
    vecs[4] = mk(0, -10, -10, -5, -5, 0,   0,   0, 40'h0,        40'h0);
    vecs[5] = mk(3,  6,  8,   5,   7, 4,   0,   0, 40'h6565,     40'h8877);
    vecs[6] = mk(1,  2,  0,   2,   2, 3,   0,   0, 40'h222,      40'h210);
    vecs[7] = mk(0, 638, 478, 700, 500, 4, 638, 478, 40'h1010,   40'h1100);
    vecs[8] = mk(1,  0,  5,   3,   5, 4,   0,   0, 40'h3210,     40'h5555);

    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.draw_ready = 1'b1;
    set_region(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst valid", longint'(bus.draw_valid), 0);
    chk("rst busy", longint'(bus.busy), 0);
    chk("rst done", longint'(bus.done), 0);
    chk("rst X", longint'(bus.draw_X), 0);
    chk("rst Y", longint'(bus.draw_Y), 0);
    chk("rst cnt", longint'(bus.pix_count), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_vec(i);

    // Backpressure: (1,0) held for three stalled cycles.
    set_region(0, 0, 0, 2, 0);
    bus.draw_ready = 1'b1;
    pulse_start();
    @(posedge clk); #1;
    chk("bp p0 X", longint'(bus.draw_X), 0);
    @(posedge clk); #1;
    chk("bp p1 X", longint'(bus.draw_X), 1);
    bus.draw_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      chk($sformatf("bp stall%0d X", s), longint'(bus.draw_X), 1);
      chk($sformatf("bp stall%0d valid", s), longint'(bus.draw_valid), 1);
      chk($sformatf("bp stall%0d cnt", s), longint'(bus.pix_count), 1);
    end
    bus.draw_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp p2 X", longint'(bus.draw_X), 2);
    chk("bp p2 cnt", longint'(bus.pix_count), 2);
    @(posedge clk); #1;
    chk("bp done", longint'(bus.done), 1);
    chk("bp total", longint'(bus.pix_count), 3);
    chk("bp hold X", longint'(bus.draw_X), 2);
    @(posedge clk); #1;

    // Abort on the third pixel of a large fill.
    set_region(0, 0, 0, 9, 9);
    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    chk("ab p2 X", longint'(bus.draw_X), 2);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    chk("ab valid", longint'(bus.draw_valid), 0);
    chk("ab busy", longint'(bus.busy), 0);
    chk("ab done", longint'(bus.done), 0);
    chk("ab cnt", longint'(bus.pix_count), 2);
    @(posedge clk); #1;
    chk("ab no done", longint'(bus.done), 0);
    chk("ab cnt hold", longint'(bus.pix_count), 2);

    // Start while busy is ignored; corners stay latched.
    set_region(0, 0, 0, 3, 0);
    pulse_start();
    set_region(0, 5, 5, 6, 6);
    bus.start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k == 1) bus.start = 1'b0;
      chk($sformatf("sb p%0d X", k), longint'(bus.draw_X), longint'(k));
      chk($sformatf("sb p%0d Y", k), longint'(bus.draw_Y), 0);
    end
    @(posedge clk); #1;
    chk("sb done", longint'(bus.done), 1);
    chk("sb total", longint'(bus.pix_count), 4);
    @(posedge clk); #1;

    // Reset in the middle of a scan.
    set_region(0, 0, 0, 9, 9);
    pulse_start();
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mr valid", longint'(bus.draw_valid), 0);
    chk("mr busy", longint'(bus.busy), 0);
    chk("mr X", longint'(bus.draw_X), 0);
    chk("mr Y", longint'(bus.draw_Y), 0);
    chk("mr cnt", longint'(bus.pix_count), 0);
    @(posedge clk); #1;
    chk("mr idle", longint'(bus.busy), 0);

    // Start together with abort in IDLE: start wins.
    set_region(0, 0, 0, 1, 0);
    bus.abort = 1'b1;
    pulse_start();
    bus.abort = 1'b0;
    chk("sa init busy", longint'(bus.busy), 1);
    @(posedge clk); #1;
    chk("sa p0 valid", longint'(bus.draw_valid), 1);
    @(posedge clk); #1;
    chk("sa p1 X", longint'(bus.draw_X), 1);
    @(posedge clk); #1;
    chk("sa done", longint'(bus.done), 1);
    chk("sa total", longint'(bus.pix_count), 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
